// File: rtl/edm_pulse_gen.sv
// edm_pulse_gen
// Discharge pulse generator that sits behind the SPI command decoder. A start
// strobe latches Ton/Toff into shadow registers and runs an ON/OFF gate pulse
// train until a stop strobe arrives, or until the Ton reloaded at the end of
// an OFF period is zero. Ton/Toff are counted in units of CLK_PER_UNIT clocks.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   machine_start  1-cycle start strobe
//   machine_stop   1-cycle stop strobe (wins over a simultaneous start)
//   Ton_data       on-time in units
//   Toff_data      off-time in units (0 is treated as 1)
//   pulse_out      registered gate drive, high during ON
//   running        high while in ON or OFF
//   pulse_cnt      ON periods since the last start, saturating
//   feedback_data  {running, zero pad, pulse_cnt}, one cycle behind
module edm_pulse_gen #(
  parameter int unsigned CLK_PER_UNIT = 50,
  parameter int unsigned CNT_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             machine_start,
  input  logic             machine_stop,
  input  logic [15:0]      Ton_data,
  input  logic [15:0]      Toff_data,
  output logic             pulse_out,
  output logic             running,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [31:0]      feedback_data
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [15:0]      PRESC_LAST = 16'(CLK_PER_UNIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_reg;
  logic [15:0]      presc_reg;
  logic [15:0]      unit_reg;
  logic [15:0]      ton_sh_reg;
  logic [15:0]      toff_sh_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pulse_reg;
  logic             running_reg;
  logic [31:0]      fb_reg;

  logic             unit_tick;
  logic [15:0]      period_len;
  logic             period_done;
  logic [15:0]      toff_clamped;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      fb_next;

  // Both shadows are non-zero while running (Ton checked before ON, Toff
  // clamped), so period_len - 1 never wraps.
  assign unit_tick    = (presc_reg == PRESC_LAST);
  assign period_len   = (state_reg == ON) ? ton_sh_reg : toff_sh_reg;
  assign period_done  = unit_tick && (unit_reg == period_len - 16'd1);
  assign toff_clamped = (Toff_data == 16'd0) ? 16'd1 : Toff_data;
  assign cnt_next     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    fb_next            = '0;
    fb_next[CNT_W-1:0] = cnt_reg;
    fb_next[31]        = running_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      unit_reg    <= '0;
      ton_sh_reg  <= '0;
      toff_sh_reg <= '0;
      cnt_reg     <= '0;
      pulse_reg   <= 1'b0;
      running_reg <= 1'b0;
      fb_reg      <= '0;
    end else begin
      fb_reg <= fb_next;
      case (state_reg)
        IDLE: begin
          if (machine_start && !machine_stop && (Ton_data != 16'd0)) begin
            state_reg   <= ON;
            pulse_reg   <= 1'b1;
            running_reg <= 1'b1;
            cnt_reg     <= CNT_W'(1);
            presc_reg   <= '0;
            unit_reg    <= '0;
            ton_sh_reg  <= Ton_data;
            toff_sh_reg <= toff_clamped;
          end
        end
        ON, OFF: begin
          if (machine_stop) begin
            // pulse_cnt is deliberately kept for host readback.
            state_reg   <= IDLE;
            pulse_reg   <= 1'b0;
            running_reg <= 1'b0;
            presc_reg   <= '0;
            unit_reg    <= '0;
          end else if (period_done) begin
            presc_reg <= '0;
            unit_reg  <= '0;
            if (state_reg == ON) begin
              state_reg <= OFF;
              pulse_reg <= 1'b0;
            end else begin
              // End of OFF: the next period always uses fresh inputs.
              ton_sh_reg  <= Ton_data;
              toff_sh_reg <= toff_clamped;
              if (Ton_data != 16'd0) begin
                state_reg <= ON;
                pulse_reg <= 1'b1;
                cnt_reg   <= cnt_next;
              end else begin
                state_reg   <= IDLE;
                running_reg <= 1'b0;
              end
            end
          end else if (unit_tick) begin
            presc_reg <= '0;
            unit_reg  <= unit_reg + 16'd1;
          end else begin
            presc_reg <= presc_reg + 16'd1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          pulse_reg   <= 1'b0;
          running_reg <= 1'b0;
          presc_reg   <= '0;
          unit_reg    <= '0;
        end
      endcase
    end
  end

  assign pulse_out     = pulse_reg;
  assign running       = running_reg;
  assign pulse_cnt     = cnt_reg;
  assign feedback_data = fb_reg;

endmodule

// File: tb/tb_edm_pulse_gen.sv
// Directed bench for edm_pulse_gen with CLK_PER_UNIT=2. A second instance with
// a 4-bit pulse counter shares the stimulus and is used for saturation checks.
module tb_edm_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        machine_start = 1'b0;
  logic        machine_stop = 1'b0;
  logic [15:0] Ton_data = '0;
  logic [15:0] Toff_data = '0;

  logic        pulse_out, running;
  logic [23:0] pulse_cnt;
  logic [31:0] feedback_data;
  logic        pulse_out_s, running_s;
  logic [3:0]  pulse_cnt_s;
  logic [31:0] feedback_data_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  edm_pulse_gen #(.CLK_PER_UNIT(2), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .machine_start(machine_start), .machine_stop(machine_stop),
    .Ton_data(Ton_data), .Toff_data(Toff_data), .pulse_out(pulse_out),
    .running(running), .pulse_cnt(pulse_cnt), .feedback_data(feedback_data)
  );

  edm_pulse_gen #(.CLK_PER_UNIT(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .machine_start(machine_start), .machine_stop(machine_stop),
    .Ton_data(Ton_data), .Toff_data(Toff_data), .pulse_out(pulse_out_s),
    .running(running_s), .pulse_cnt(pulse_cnt_s), .feedback_data(feedback_data_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic        exp_p;
    int          exp_n;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_pulse", {31'd0, pulse_out}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_cnt", {8'd0, pulse_cnt}, 32'd0);
    chk("rst_fb", feedback_data, 32'd0);

    // Ton=3, Toff=2; Ton changed to 1 mid-ON (c=22) and back to 3 in OFF
    // (c=33); stop in the 3rd cycle of the last ON period (c=39).
    Ton_data = 16'd3; Toff_data = 16'd2; machine_start = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      tick();
      exp_p = (c <= 6) || (c >= 11 && c <= 16) || (c >= 21 && c <= 26) ||
              (c >= 31 && c <= 32) || (c >= 37);
      exp_n = (c <= 10) ? 1 : (c <= 20) ? 2 : (c <= 30) ? 3 : (c <= 36) ? 4 : 5;
      chk("train_pulse", {31'd0, pulse_out}, {31'd0, exp_p});
      chk("train_running", {31'd0, running}, 32'd1);
      chk("train_cnt", {8'd0, pulse_cnt}, exp_n);
      if (c == 1) begin
        chk("fb_lag", feedback_data, 32'd0);
        machine_start = 1'b0;
      end
      if (c == 2) chk("fb_first", feedback_data, 32'h8000_0001);
      if (c == 22) Ton_data = 16'd1;
      if (c == 33) Ton_data = 16'd3;
      if (c == 39) machine_stop = 1'b1;
    end
    tick();
    machine_stop = 1'b0;
    chk("stop_pulse", {31'd0, pulse_out}, 32'd0);
    chk("stop_running", {31'd0, running}, 32'd0);
    chk("stop_cnt", {8'd0, pulse_cnt}, 32'd5);
    chk("stop_fb_lag", feedback_data, 32'h8000_0005);
    tick();
    chk("stop_fb", feedback_data, 32'h0000_0005);

    // Start with Ton=0 is ignored
    Ton_data = 16'd0; machine_start = 1'b1;
    tick();
    machine_start = 1'b0;
    chk("ton0_pulse", {31'd0, pulse_out}, 32'd0);
    chk("ton0_running", {31'd0, running}, 32'd0);
    tick();
    chk("ton0_cnt", {8'd0, pulse_cnt}, 32'd5);

    // Start and stop in the same cycle: stop wins
    Ton_data = 16'd3; machine_start = 1'b1; machine_stop = 1'b1;
    tick();
    machine_start = 1'b0; machine_stop = 1'b0;
    chk("both_pulse", {31'd0, pulse_out}, 32'd0);
    chk("both_running", {31'd0, running}, 32'd0);

    // Toff=0 clamps to one unit (2 cycles)
    Ton_data = 16'd1; Toff_data = 16'd0; machine_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) machine_start = 1'b0;
      exp_p = (c <= 2) || (c >= 5);
      chk("toff0_pulse", {31'd0, pulse_out}, {31'd0, exp_p});
      chk("toff0_cnt", {8'd0, pulse_cnt}, (c <= 4) ? 32'd1 : 32'd2);
    end
    machine_stop = 1'b1;
    tick();
    machine_stop = 1'b0;
    chk("toff0_stop", {31'd0, running}, 32'd0);

    // Reset during ON, then a fresh start behaves as from power-up
    Ton_data = 16'd3; Toff_data = 16'd2; machine_start = 1'b1;
    tick();
    machine_start = 1'b0;
    chk("pre_rst_pulse", {31'd0, pulse_out}, 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_pulse", {31'd0, pulse_out}, 32'd0);
    chk("mrst_running", {31'd0, running}, 32'd0);
    chk("mrst_cnt", {8'd0, pulse_cnt}, 32'd0);
    chk("mrst_fb", feedback_data, 32'd0);
    chk("mrst_sat_cnt", {28'd0, pulse_cnt_s}, 32'd0);
    rst = 1'b0;
    Ton_data = 16'd2; Toff_data = 16'd1; machine_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        machine_start = 1'b0;
        chk("post_fb_lag", feedback_data, 32'd0);
      end
      if (c == 2) chk("post_fb", feedback_data, 32'h8000_0001);
      exp_p = (c <= 4) || (c >= 7);
      chk("post_pulse", {31'd0, pulse_out}, {31'd0, exp_p});
      chk("post_cnt", {8'd0, pulse_cnt}, (c <= 6) ? 32'd1 : 32'd2);
    end
    machine_stop = 1'b1;
    tick();
    machine_stop = 1'b0;

    // Saturation with Ton=Toff=1: one ON entry every 4 cycles
    Ton_data = 16'd1; Toff_data = 16'd1; machine_start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c == 1) machine_start = 1'b0;
      if (c % 4 == 1) begin
        exp_n = (c - 1) / 4 + 1;
        chk("sat_cnt", {28'd0, pulse_cnt_s}, (exp_n > 15) ? 32'd15 : exp_n);
        chk("wide_cnt", {8'd0, pulse_cnt}, exp_n);
      end
      if (c == 80) chk("sat_fb", feedback_data_s, 32'h8000_000F);
    end
    machine_stop = 1'b1;
    tick();
    machine_stop = 1'b0;
    chk("sat_stop_cnt", {28'd0, pulse_cnt_s}, 32'd15);
    chk("sat_stop_run", {31'd0, running_s}, 32'd0);
    tick();
    machine_start = 1'b1;
    tick();
    machine_start = 1'b0;
    chk("restart_cnt", {28'd0, pulse_cnt_s}, 32'd1);
    chk("restart_pulse", {31'd0, pulse_out_s}, 32'd1);
    machine_stop = 1'b1;
    tick();
    machine_stop = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
